alu_multicycle_exec: RTL and testbench
======================================

// Module: alu_multicycle_exec
// PURPOSE
//  Execute stage directly downstream of the ALU control decoder. Consumes the 4-bit ALU operation code and two operands.
//  Single-cycle ops (add/sub/and/or/lui) finish in one cycle. Shifts are iterative, one bit per clock.
//  Start/busy/done handshake lets the core stall the datapath while a shift is in flight.
// PARAMETERS
//  DATA_WIDTH   32  operand/result width
//  SHAMT_WIDTH  5   shift-amount width; shamt = B_i[SHAMT_WIDTH-1:0]
// PORTS
//  clk              in   1           clock, rising edge
//  reset            in   1           asynchronous, active-high reset
//  start_i          in   1           request; accepted only in IDLE
//  ALU_Operation_i  in   4           op code: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 LUI, 0110 SRL, 0111 SLL
//  A_i              in   DATA_WIDTH  operand A (rs1)
//  B_i              in   DATA_WIDTH  operand B (rs2 or immediate)
//  busy_o           out  1           high whenever state != IDLE
//  done_o           out  1           one-cycle pulse; ALU_Result_o is valid from this cycle on
//  ALU_Result_o     out  DATA_WIDTH  registered result; held until the next accepted op completes
//  Zero_o           out  1           (ALU_Result_o == 0), combinational from the result register
// BEHAVIOUR
//  Reset: state=IDLE, busy_o=0, done_o=0, ALU_Result_o=0 (so Zero_o=1), shift counter=0.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE, start_i=1 (edge N): capture op, A_i and B_i; no input is sampled again until the op completes.
//   - ADD/SUB/AND/OR/LUI: result register loaded at edge N; go to DONE.
//   - SRL/SLL with shamt=0: result=A; go to DONE.
//   - SRL/SLL with shamt=s>0: working reg=A, cnt=s; go to SHIFT.
//   - Undefined op code: result=0; go to DONE (latency 1, no error flag).
//  SHIFT: each cycle shift working reg by 1 (SRL logical, zero fill; SLL zero fill) and decrement cnt.
//   - On the cycle cnt==1: write the final value to ALU_Result_o and go to DONE.
//   - Exactly s cycles are spent in SHIFT.
//  DONE: done_o=1 for exactly one cycle, then IDLE. start_i is ignored in DONE and SHIFT (not queued).
//  Latency, start to done_o: 1 cycle for non-shift ops; 1+s cycles for shifts.
//  Minimum issue interval: 2 cycles (op completes, then one IDLE cycle).
//  Arithmetic: ADD/SUB are modulo 2^DATA_WIDTH; carry/overflow discarded. LUI: result=B_i (immediate arrives pre-shifted).
//  ALU_Result_o changes only when a result is written (IDLE accept for 1-cycle ops, last SHIFT cycle for shifts). It is stable otherwise.
//  Inputs may change freely after the accept edge; they do not affect an op in flight.
//  Reset asserted mid-operation: abort immediately; all outputs return to reset values; no done_o pulse.
//  start_i held high continuously: ops are accepted back-to-back at the 2-cycle minimum interval, each with its own done_o.
// TESTING
//  1. Reset with random inputs -> busy_o=0, done_o=0, ALU_Result_o=0, Zero_o=1.
//  2. ADD A=0xFFFFFFFF, B=1 -> done_o one cycle after start; result 0x00000000, Zero_o=1.
//     SUB A=5, B=7 -> result 0xFFFFFFFE.
//  3. SLL A=0x00000001, B=31 -> busy_o for 32 cycles, done_o at cycle 32, result 0x80000000.
//     SRL A=0x80000000, shamt=4 -> result 0x08000000 after 5 cycles.
//  4. SRL shamt=0, A=0x1234 -> done_o after 1 cycle, result 0x1234.
//     A second start_i pulse while busy -> ignored, one done_o only.
//  5. Reset pulsed mid-shift (SLL shamt=20, reset at cycle 10) -> no done_o; outputs at reset values.
//     Next op after release (OR 0xF0 | 0x0F) -> result 0xFF.
//  6. Undefined op 1111 -> result 0, Zero_o=1, latency 1.
//     LUI B=0xABCDE000 -> result 0xABCDE000.

Source files
------------

// File: rtl/alu_multicycle_exec.sv
// alu_multicycle_exec: execute stage with single-cycle ALU ops and bit-serial shifts under a start/busy/done handshake.
module alu_multicycle_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]             state;
  logic [DATA_WIDTH-1:0]  work;
  logic [SHAMT_WIDTH-1:0] cnt;
  logic                   left;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   is_shift;
  logic [DATA_WIDTH-1:0]  op_res;
  logic [DATA_WIDTH-1:0]  work_next;
  always_comb begin
    shamt     = B_i[SHAMT_WIDTH-1:0];
    is_shift  = (ALU_Operation_i == 4'b0110) || (ALU_Operation_i == 4'b0111);
    op_res    = (ALU_Operation_i == 4'b0000) ? A_i + B_i :
                (ALU_Operation_i == 4'b0001) ? A_i - B_i :
                (ALU_Operation_i == 4'b0010) ? A_i & B_i :
                (ALU_Operation_i == 4'b0011) ? A_i | B_i :
                (ALU_Operation_i == 4'b0101) ? B_i :
                is_shift ? A_i : '0;
    work_next = left ? work << 1 : work >> 1;
  end
  // a zero shift amount completes like a single-cycle op, returning A unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      work         <= '0;
      cnt          <= '0;
      left         <= 1'b0;
      ALU_Result_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          if (is_shift && shamt != '0) begin
            work  <= A_i;
            cnt   <= shamt;
            left  <= ALU_Operation_i[0];
            state <= SHIFT;
          end else begin
            ALU_Result_o <= op_res;
            state        <= DONE;
          end
        end
        SHIFT: begin
          work <= work_next;
          cnt  <= cnt - SHAMT_WIDTH'(1);
          if (cnt == SHAMT_WIDTH'(1)) begin
            ALU_Result_o <= work_next;
            state        <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign Zero_o = ALU_Result_o == '0;
endmodule

// File: tb/tb_alu_multicycle_exec.sv
// tb_alu_multicycle_exec: directed and random checks of alu_multicycle_exec against an arithmetic reference model.
module tb_alu_multicycle_exec;
  logic        clk;
  logic        reset;
  logic        start_i;
  logic [3:0]  ALU_Operation_i;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] ALU_Result_o;
  logic        Zero_o;
  int checks = 0;
  int errors = 0;
  alu_multicycle_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .ALU_Operation_i(ALU_Operation_i),
    .A_i(A_i), .B_i(B_i), .busy_o(busy_o), .done_o(done_o),
    .ALU_Result_o(ALU_Result_o), .Zero_o(Zero_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd5: return b;
      4'd6: return a >> s;
      4'd7: return a << s;
      default: return 32'd0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [31:0] exp_r;
    int exp_lat;
    int lat;
    int extra;
    exp_r = model(op, a, b);
    exp_lat = ((op == 4'd6 || op == 4'd7) && b[4:0] != 5'd0) ? 1 + int'(b[4:0]) : 1;
    @(negedge clk);
    start_i = 1'b1; ALU_Operation_i = op; A_i = a; B_i = b;
    @(negedge clk);
    start_i = 1'b0; A_i = $urandom; B_i = $urandom; ALU_Operation_i = 4'($urandom);
    lat = 1;
    while (!done_o && lat < 64) begin
      if (poke && lat == 1) start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      lat++;
    end
    chk("done_seen", 32'(done_o), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("result", ALU_Result_o, exp_r);
    chk("zero", 32'(Zero_o), 32'(exp_r == 32'd0));
    chk("busy_at_done", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("done_pulse_end", 32'(done_o), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("result_held", ALU_Result_o, exp_r);
    if (poke) begin
      extra = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (done_o) extra++;
      end
      chk("ignored_start", 32'(extra), 32'd0);
    end
  endtask
  initial begin
    int dones;
    logic [3:0] op;
    reset = 1'b1; start_i = 1'b1;
    ALU_Operation_i = 4'($urandom); A_i = $urandom; B_i = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", ALU_Result_o, 32'd0);
    chk("rst_zero", 32'(Zero_o), 32'd1);
    start_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(4'd1, 32'd5, 32'd7, 1'b0);
    run_op(4'd7, 32'h0000_0001, 32'd31, 1'b0);
    run_op(4'd6, 32'h8000_0000, 32'd4, 1'b0);
    run_op(4'd6, 32'h0000_1234, 32'hFFFF_FFE0, 1'b0);
    run_op(4'd7, 32'hDEAD_BEEF, 32'd6, 1'b1);
    run_op(4'd6, 32'hCAFE_F00D, 32'd1, 1'b1);
    @(negedge clk);
    start_i = 1'b1; ALU_Operation_i = 4'd7; A_i = 32'h0000_0003; B_i = 32'd20;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_result", ALU_Result_o, 32'd0);
    chk("abort_zero", 32'(Zero_o), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_op(4'd3, 32'h0000_00F0, 32'h0000_000F, 1'b0);
    run_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    run_op(4'd5, 32'h1111_1111, 32'hABCD_E000, 1'b0);
    @(negedge clk);
    start_i = 1'b1; ALU_Operation_i = 4'd0; A_i = 32'd10; B_i = 32'd20;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    start_i = 1'b0;
    chk("b2b_dones", 32'(dones), 32'd4);
    chk("b2b_result", ALU_Result_o, 32'd30);
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      if (i % 3 == 0) op = $urandom_range(0, 1) != 0 ? 4'd6 : 4'd7;
      run_op(op, $urandom, $urandom, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
